// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode map, instruction field positions and fetch state shared by
// the fetch sequencer and the control unit.
package cpu_pkg;
    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_ADC  = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_SDC  = 5'd4;
    localparam logic [4:0] OP_SBB  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_XOR  = 5'd8;
    localparam logic [4:0] OP_NOT  = 5'd9;
    localparam logic [4:0] OP_SHFT = 5'd10;
    localparam logic [4:0] OP_MOV  = 5'd11;
    localparam logic [4:0] OP_JMP  = 5'd12;
    localparam logic [4:0] OP_JGO  = 5'd13;
    localparam logic [4:0] OP_JLO  = 5'd14;
    localparam logic [4:0] OP_JEO  = 5'd15;
    localparam logic [4:0] OP_HLT  = 5'd16;
    localparam logic [4:0] OP_RST  = 5'd17;
    localparam logic [4:0] OP_SETH = 5'd18;
    localparam logic [4:0] OP_SETL = 5'd19;

    localparam int OPP_LSB = 11;
    localparam int R1_LSB  = 8;
    localparam int R2_LSB  = 5;
    localparam int QR_LSB  = 2;
    localparam int RES_LSB = 0;

    typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_HALT} fetch_state_e;

    function automatic logic op_reserved(input logic [4:0] op);
        return op > OP_SETL;
    endfunction
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction memory, decode handshake and datapath feedback
// bundle; master is the sequencer, slave is memory/control unit/datapath.
interface fetch_sequencer_if #(parameter int ADDR_W = 16);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_rdata;
    logic              dec_valid;
    logic              dec_ready;
    logic [4:0]        opp;
    logic [2:0]        R1;
    logic [2:0]        R2;
    logic [2:0]        QR;
    logic [1:0]        RES;
    logic [ADDR_W-1:0] jmp_target;
    logic              flag_gt;
    logic              flag_lt;
    logic              flag_eq;
    logic              resume;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              illegal;
    modport master (
        output imem_req, imem_addr, dec_valid, opp, R1, R2, QR, RES, pc, halted, illegal,
        input  imem_ack, imem_rdata, dec_ready, jmp_target, flag_gt, flag_lt, flag_eq, resume
    );
    modport slave (
        input  imem_req, imem_addr, dec_valid, opp, R1, R2, QR, RES, pc, halted, illegal,
        output imem_ack, imem_rdata, dec_ready, jmp_target, flag_gt, flag_lt, flag_eq, resume
    );
endinterface

// File: rtl/fetch_sequencer_pc_next_sel.sv
// pc_next_sel: next PC for an issued instruction (jump target or pc+1 with wrap).
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [4:0]        op,
    input  logic              flag_gt,
    input  logic              flag_lt,
    input  logic              flag_eq,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic [ADDR_W-1:0] pc_next
);
    logic taken;
    always_comb begin
        taken = (op == OP_JMP) || (op == OP_JGO && flag_gt) ||
                (op == OP_JLO && flag_lt) || (op == OP_JEO && flag_eq);
        pc_next = taken ? jmp_target : pc + ADDR_W'(1);
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner, instruction fetch and decode issue with jump/halt/reset handling.
// Define FETCH_ILLEGAL_TRAP_EN to halt on reserved opcodes instead of skipping them.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic            clk,
    input logic            rst,
    fetch_sequencer_if.master bus
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_issue;
    logic [15:0]       ir_q, ir_d;
    logic              illegal_q, illegal_d;
    logic [4:0]        op;

    assign op = ir_q[OPP_LSB +: 5];

    pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
        .pc(pc_q),
        .op(op),
        .flag_gt(bus.flag_gt),
        .flag_lt(bus.flag_lt),
        .flag_eq(bus.flag_eq),
        .jmp_target(bus.jmp_target),
        .pc_next(pc_issue)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: if (bus.imem_ack) begin
                ir_d    = bus.imem_rdata;
                state_d = S_ISSUE;
            end
            S_ISSUE: if (op == OP_HLT) begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_HALT;
            end else if (op == OP_RST) begin
                pc_d      = RESET_PC;
                illegal_d = 1'b0;
                state_d   = S_FETCH;
            end else if (op_reserved(op)) begin
                illegal_d = 1'b1;
`ifdef FETCH_ILLEGAL_TRAP_EN
                state_d   = S_HALT;
`else
                pc_d      = pc_q + ADDR_W'(1);
                state_d   = S_FETCH;
`endif
            end else if (bus.dec_ready) begin
                pc_d    = pc_issue;
                state_d = S_FETCH;
            end
            S_HALT: state_d = bus.resume ? S_FETCH : S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Only decoded state and registers reach the outputs; rst gates the request.
    always_comb begin
        bus.imem_req  = state_q == S_FETCH && !rst;
        bus.imem_addr = pc_q;
        bus.dec_valid = state_q == S_ISSUE && op != OP_HLT && op != OP_RST && !op_reserved(op);
        bus.opp       = op;
        bus.R1        = ir_q[R1_LSB +: 3];
        bus.R2        = ir_q[R2_LSB +: 3];
        bus.QR        = ir_q[QR_LSB +: 3];
        bus.RES       = ir_q[RES_LSB +: 2];
        bus.pc        = pc_q;
        bus.halted    = state_q == S_HALT;
        bus.illegal   = illegal_q;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed plus random instruction streams checked against
// a transaction-level model of pc, illegal and halt behaviour.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [15:0] m_pc = 16'h0000;
    logic        m_ill = 1'b0;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(16)) bus ();

    fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fields(input string tag, input logic [15:0] ins);
        check({tag, "_valid"}, bus.dec_valid, 1);
        check({tag, "_opp"}, bus.opp, ins[15:11]);
        check({tag, "_r1"}, bus.R1, ins[10:8]);
        check({tag, "_r2"}, bus.R2, ins[7:5]);
        check({tag, "_qr"}, bus.QR, ins[4:2]);
        check({tag, "_res"}, bus.RES, ins[1:0]);
    endtask

    task automatic leave_halt();
        for (int i = 0; i < 2; i++) begin
            tick();
            check("halt_hold", bus.halted, 1);
            check("halt_noreq", bus.imem_req, 0);
        end
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        check("resume", bus.halted, 0);
    endtask

    task automatic run(input logic [15:0] ins, input int dly, input int bp,
                       input logic gt, input logic lt, input logic eq, input logic [15:0] tgt);
        int   n = 0;
        int   o;
        logic take;
        o = int'(ins[15:11]);
        while (!bus.imem_req && n < 20) begin
            tick();
            n++;
        end
        check("req_wait", bus.imem_req, 1);
        check("addr", bus.imem_addr, m_pc);
        check("pc", bus.pc, m_pc);
        for (int i = 0; i < dly; i++) begin
            bus.imem_rdata = 16'($urandom);
            bus.resume = 1'($urandom);
            tick();
            bus.resume = 1'b0;
            check("fetch_hold", bus.imem_req, 1);
            check("fetch_pc", bus.pc, m_pc);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = ins;
        tick();
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 16'($urandom);
        check("issue_noreq", bus.imem_req, 0);
        if (o <= 15 || o == 18 || o == 19) begin
            check_fields("issue", ins);
            for (int i = 0; i < bp; i++) begin
                bus.flag_gt = 1'($urandom);
                bus.flag_lt = 1'($urandom);
                bus.flag_eq = 1'($urandom);
                bus.jmp_target = 16'($urandom);
                tick();
                check_fields("stall", ins);
                check("stall_pc", bus.pc, m_pc);
            end
            bus.flag_gt = gt;
            bus.flag_lt = lt;
            bus.flag_eq = eq;
            bus.jmp_target = tgt;
            bus.dec_ready = 1'b1;
            tick();
            bus.dec_ready = 1'b0;
            take = (o == 12) || (o == 13 && gt) || (o == 14 && lt) || (o == 15 && eq);
            m_pc = take ? tgt : m_pc + 16'd1;
            check("accept_drop", bus.dec_valid, 0);
        end else if (o == 16) begin
            check("hlt_novalid", bus.dec_valid, 0);
            tick();
            m_pc = m_pc + 16'd1;
            check("hlt_halted", bus.halted, 1);
            check("hlt_pc", bus.pc, m_pc);
            check("hlt_novalid2", bus.dec_valid, 0);
            leave_halt();
        end else if (o == 17) begin
            check("rst_novalid", bus.dec_valid, 0);
            tick();
            m_pc = 16'h0000;
            m_ill = 1'b0;
        end else begin
            check("rsv_novalid", bus.dec_valid, 0);
            tick();
            m_ill = 1'b1;
`ifdef FETCH_ILLEGAL_TRAP_EN
            check("rsv_halted", bus.halted, 1);
            check("rsv_pc", bus.pc, m_pc);
            leave_halt();
`else
            m_pc = m_pc + 16'd1;
            check("rsv_halted", bus.halted, 0);
`endif
        end
        check("illegal", bus.illegal, m_ill);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ins;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'h0A53;
        bus.dec_ready = 1'b1;
        bus.jmp_target = 16'h1234;
        bus.flag_gt = 1'b0;
        bus.flag_lt = 1'b0;
        bus.flag_eq = 1'b0;
        bus.resume = 1'b0;
        tick();
        tick();
        check("rst_req", bus.imem_req, 0);
        rst = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dec_ready = 1'b0;
        #1;
        check("por_req", bus.imem_req, 1);
        check("por_addr", bus.imem_addr, 16'h0000);
        check("por_valid", bus.dec_valid, 0);
        check("por_opp", bus.opp, 0);
        check("por_res", bus.RES, 0);
        check("por_halted", bus.halted, 0);
        check("por_illegal", bus.illegal, 0);
        run(16'h0A53, 0, 0, 0, 0, 0, 16'h0000);
        run(16'h0A53, 1, 5, 1, 1, 1, 16'h0555);
        run(16'h7800, 0, 0, 0, 0, 1, 16'h0040);
        run(16'h7800, 0, 1, 1, 1, 0, 16'h0080);
        run(16'h6800, 2, 0, 0, 1, 0, 16'h0090);
        run(16'h6000, 0, 0, 0, 0, 0, 16'hFFFF);
        run(16'h0800, 0, 0, 0, 0, 0, 16'h0123);
        run(16'h8000, 0, 0, 0, 0, 0, 16'h0000);
        run(16'hF800, 0, 0, 0, 0, 0, 16'h0000);
        run(16'h8800, 1, 0, 0, 0, 0, 16'h0000);
        for (int k = 0; k < 300; k++) begin
            ins = 16'($urandom);
            run(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        end
        run(16'hF800, 0, 0, 0, 0, 0, 16'h0000);
        run(16'h7800, 0, 0, 0, 0, 1, 16'h0200);
        while (!bus.imem_req) tick();
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'h0A53;
        tick();
        bus.imem_ack = 1'b0;
        check("pre_abort_valid", bus.dec_valid, 1);
        rst = 1'b1;
        #1;
        check("abort_valid", bus.dec_valid, 0);
        check("abort_opp", bus.opp, 0);
        check("abort_req", bus.imem_req, 0);
        check("abort_pc", bus.pc, 16'h0000);
        check("abort_halted", bus.halted, 0);
        check("abort_illegal", bus.illegal, 0);
        tick();
        rst = 1'b0;
        #1;
        check("post_abort_req", bus.imem_req, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
